sector_fill_ctrl: RTL and testbench
===================================

// Module: sector_fill_ctrl
// PURPOSE
//  Loads one 512-byte disk sector from the upstream read-channel byte stream into the
//  single-sector cache write port. Hunts for the sector sync byte, then writes data bytes
//  sequentially at addresses 0..511. Reports done/error to the drive controller FSM.
//  Sits between the bit deserializer (upstream) and the cache (downstream, port B).
// PARAMETERS
//  SYNC_BYTE     8'hA1  byte value that marks the start of the sector data field
//  HUNT_LIMIT    64     max bytes accepted in HUNT before a timeout error (1..255)
// PORTS
//  clk           in   1   single clock
//  rst_n         in   1   asynchronous active-low reset
//  start         in   1   1-cycle pulse: begin loading a sector (ignored unless IDLE)
//  abort         in   1   level: abandon the current load, return to IDLE
//  in_data       in   8   stream byte from the deserializer
//  in_valid      in   1   in_data valid
//  in_ready      out  1   block accepts in_data; transfer when in_valid & in_ready
//  cache_addr    out  9   cache write address
//  cache_din     out  8   cache write data
//  cache_wr_en   out  1   cache write strobe, 1 cycle per data byte
//  busy          out  1   high in any state other than IDLE
//  done          out  1   1-cycle pulse when the load ends (success or error)
//  err_code      out  2   0 ok, 1 hunt timeout, 2 CRC mismatch, 3 aborted; held until next start
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, byte counter 0, err_code 0.
//  States: IDLE -> HUNT (start) -> DATA (SYNC_BYTE accepted) -> [CRC] -> DONE -> IDLE.
//  IDLE: in_ready=0. start clears err_code and the byte counter and enters HUNT next cycle.
//  HUNT: in_ready=1. Each accepted byte != SYNC_BYTE increments the hunt count; when the
//   HUNT_LIMIT-th non-sync byte is accepted -> DONE with err_code=1. The sync byte is not written.
//  DATA: in_ready=1. Each accepted byte is written registered: next cycle cache_wr_en=1,
//   cache_addr=count, cache_din=byte. count is 9 bits, 0..511. Acceptance of byte 511
//   -> CRC (if CRC16_EN) else DONE. No write without an accepted byte; gaps in in_valid stall.
//  DONE: in_ready=0, done=1 for exactly one cycle, then IDLE. The last cache write
//   (addr 511) is issued in the same cycle as done; it is never dropped.
//  abort: from HUNT/DATA/CRC -> DONE next cycle, err_code=3; a write already registered
//   still issues. abort in IDLE/DONE has no effect. abort wins over a simultaneous sync/last byte.
//  start during busy is ignored; start and abort in the same IDLE cycle: abort wins, stay IDLE.
//  Reset mid-load: immediate return to IDLE; the partially filled cache is not cleared.
// CONFIGURATION
//  SECTOR_CRC16_EN defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) computed over
//   the 512 data bytes; after DATA, state CRC accepts 2 further bytes (CRC high, then low),
//   not written to cache. Residue != 0x0000 after both -> err_code=2, else 0. Then DONE.
//  Undefined: no CRC state, no CRC logic; DATA goes straight to DONE; err_code 2 never occurs.
// STRUCTURE
//  Package sector_pkg: SECTOR_BYTES=512, ADDR_W=9, state enum
//   {S_IDLE,S_HUNT,S_DATA,S_CRC,S_DONE}, err-code constants, CRC16_POLY/CRC16_INIT.
//  Sub-module crc16_ccitt_byte (combinational next-CRC for one byte), instantiated only
//   under SECTOR_CRC16_EN; CRC register lives in sector_fill_ctrl.
// TESTING
//  1 start, 3 junk bytes, 8'hA1, bytes i&8'hFF for i=0..511 -> 512 writes addr=i data=i, done,
//    err_code=0 (build without CRC).
//  2 start, 64 bytes of 8'h00 with no sync -> done on 64th accepted byte, err_code=1, no writes.
//  3 As 1 with random in_valid gaps (~50%) -> identical write sequence, done once.
//  4 abort asserted after 100 data bytes -> done next cycle, err_code=3, exactly 100 writes.
//  5 SECTOR_CRC16_EN: 512 bytes of 8'h00 + correct CRC bytes -> err_code=0; same with
//    low CRC byte flipped -> err_code=2; the 2 CRC bytes never written to cache.
//  6 start pulsed during DATA, and rst_n dropped mid-DATA -> start ignored; reset forces IDLE,
//    all outputs 0, a new load then completes normally.

Source files
------------

// File: rtl/sector_pkg.sv
// Shared types and constants for the sector fill path (sector_fill_ctrl and its CRC helper).
package sector_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int ADDR_W       = 9;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SECTOR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUNT,
    S_DATA,
    S_CRC,
    S_DONE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_CRC     = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16-CCITT update for one byte, MSB first; used only when SECTOR_CRC16_EN is defined.
module crc16_ccitt_byte
  import sector_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // NOTE: the loop walks a running value bit by bit, so blocking assignments are
  // required here; assigning crc_out first also keeps the block latch-free.
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ data[i])
        crc_out = {crc_out[14:0], 1'b0} ^ CRC16_POLY;
      else
        crc_out = {crc_out[14:0], 1'b0};
    end
  end

endmodule

// File: rtl/sector_fill_ctrl.sv
// Loads one 512-byte sector from the read-channel byte stream into the cache write port.
// Optional trailer check: define SECTOR_CRC16_EN to verify a CRC-16-CCITT after the data field.
module sector_fill_ctrl
  import sector_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = 8'hA1,
  parameter int         HUNT_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [7:0]        cache_din,
  output logic              cache_wr_en,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code
);

  localparam logic [7:0] HUNT_LAST = 8'(HUNT_LIMIT - 1);

  state_t            state;
  logic [ADDR_W-1:0] byte_cnt;
  logic [7:0]        hunt_cnt;
  logic              accept;

  // Both are pure decodes of the state register, so they change only on a clock edge.
  assign in_ready = (state == S_HUNT) || (state == S_DATA) || (state == S_CRC);
  assign busy     = (state != S_IDLE);
  assign accept   = in_valid && in_ready;

`ifdef SECTOR_CRC16_EN
  logic [15:0] crc;
  logic [15:0] crc_nxt;
  logic        crc_second;

  crc16_ccitt_byte u_crc (
    .crc_in  (crc),
    .data    (in_data),
    .crc_out (crc_nxt)
  );
`endif

  // NOTE: all state and registered outputs update with non-blocking assignments so
  // every branch below sees the pre-edge values of the registers it reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      hunt_cnt    <= '0;
      err_code    <= ERR_OK;
      done        <= 1'b0;
      cache_wr_en <= 1'b0;
      cache_addr  <= '0;
      cache_din   <= '0;
`ifdef SECTOR_CRC16_EN
      crc         <= CRC16_INIT;
      crc_second  <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      cache_wr_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            state    <= S_HUNT;
            err_code <= ERR_OK;
            byte_cnt <= '0;
            hunt_cnt <= '0;
`ifdef SECTOR_CRC16_EN
            crc        <= CRC16_INIT;
            crc_second <= 1'b0;
`endif
          end
        end
        S_HUNT: begin
          if (abort) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (accept) begin
            if (in_data == SYNC_BYTE) begin
              state <= S_DATA;
            end else if (hunt_cnt == HUNT_LAST) begin
              state    <= S_DONE;
              done     <= 1'b1;
              err_code <= ERR_TIMEOUT;
            end else begin
              hunt_cnt <= hunt_cnt + 8'd1;
            end
          end
        end
        S_DATA: begin
          // An abort coinciding with a transfer drops that byte: no write is issued.
          if (abort) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (accept) begin
            cache_wr_en <= 1'b1;
            cache_addr  <= byte_cnt;
            cache_din   <= in_data;
            byte_cnt    <= byte_cnt + 1'b1;
`ifdef SECTOR_CRC16_EN
            crc <= crc_nxt;
            if (byte_cnt == LAST_ADDR) state <= S_CRC;
`else
            if (byte_cnt == LAST_ADDR) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
`endif
          end
        end
`ifdef SECTOR_CRC16_EN
        S_CRC: begin
          if (abort) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err_code <= ERR_ABORT;
          end else if (accept) begin
            // Feeding the transmitted CRC through the register leaves a zero residue when intact.
            crc        <= crc_nxt;
            crc_second <= 1'b1;
            if (crc_second) begin
              state    <= S_DONE;
              done     <= 1'b1;
              err_code <= (crc_nxt == 16'h0000) ? ERR_OK : ERR_CRC;
            end
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sector_fill_ctrl.sv
// Directed self-checking bench for sector_fill_ctrl; CRC vectors run when SECTOR_CRC16_EN is defined.
module tb_sector_fill_ctrl;
  import sector_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, in_valid;
  logic [7:0] in_data;
  logic       in_ready, cache_wr_en, busy, done;
  logic [8:0] cache_addr;
  logic [7:0] cache_din;
  logic [1:0] err_code;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sector_fill_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .cache_addr  (cache_addr),
    .cache_din   (cache_din),
    .cache_wr_en (cache_wr_en),
    .busy        (busy),
    .done        (done),
    .err_code    (err_code)
  );

  // Write/done monitor sampled on the falling edge.
  logic [8:0] wa_q[$];
  logic [7:0] wd_q[$];
  int         done_cnt = 0;
  int         last_with_done = 0;
  logic [1:0] done_err = 2'd0;

  always @(negedge clk) begin
    if (cache_wr_en === 1'b1) begin
      wa_q.push_back(cache_addr);
      wd_q.push_back(cache_din);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_err = err_code;
      if (cache_wr_en === 1'b1 && cache_addr == 9'd511) last_with_done++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int   n;
    logic acc;
    if (gaps && $urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) tick();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (acc !== 1'b1 && n < 50);
    if (acc !== 1'b1) check("send_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load(input int nbytes, input bit gaps, input bit zero);
    send(8'h12, gaps);
    send(8'h34, gaps);
    send(8'h56, gaps);
    send(8'hA1, gaps);
    for (int i = 0; i < nbytes; i++) send(zero ? 8'h00 : 8'(i), gaps);
  endtask

  task automatic wait_done(input int base_done);
    int n = 0;
    while (done_cnt == base_done && n < 20) begin
      tick();
      n++;
    end
    repeat (2) tick();
  endtask

  task automatic check_writes(input string tag, input int base, input int exp_n, input bit zero);
    int bad = 0;
    int got = wa_q.size() - base;
    check(tag, 32'(got), 32'(exp_n));
    for (int i = 0; i < got && i < exp_n; i++)
      if (wa_q[base+i] !== 9'(i) || wd_q[base+i] !== (zero ? 8'h00 : 8'(i))) bad++;
    check(tag, 32'(bad), 32'd0);
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r = c;
    for (int i = 7; i >= 0; i--) r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    return r;
  endfunction

  task automatic full_load(input string tag, input bit gaps);
    int wb = wa_q.size();
    int db = done_cnt;
    int lb = last_with_done;
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_ready", 32'(in_ready), 32'd1);
    check("start_err_clear", 32'(err_code), 32'(ERR_OK));
    load(512, gaps, 1'b0);
    wait_done(db);
    check(tag, 32'(done_cnt - db), 32'd1);
    check(tag, 32'(done_err), 32'(ERR_OK));
    check(tag, 32'(last_with_done - lb), 32'd1);
    check(tag, 32'(busy), 32'd0);
    check_writes(tag, wb, 512, 1'b0);
  endtask

  initial begin
    int wb, db;
`ifdef SECTOR_CRC16_EN
    logic [15:0] c;
`endif
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    check("reset_outputs", {11'd0, in_ready, busy, done, cache_wr_en, err_code, cache_addr, cache_din}, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: clean sector, contiguous stream
    full_load("t1_sector", 1'b0);

    // 2: hunt timeout on the 64th non-sync byte
    wb = wa_q.size(); db = done_cnt;
    pulse_start();
    for (int i = 0; i < 63; i++) send(8'h00, 1'b0);
    check("t2_no_done_at_63", 32'(done_cnt - db), 32'd0);
    check("t2_busy_at_63", 32'(busy), 32'd1);
    send(8'h00, 1'b0);
    check("t2_done_pulse", 32'(done), 32'd1);
    check("t2_err_timeout", 32'(err_code), 32'(ERR_TIMEOUT));
    tick();
    check("t2_done_one_cycle", 32'(done), 32'd0);
    check("t2_idle", 32'(busy), 32'd0);
    check("t2_no_writes", 32'(wa_q.size() - wb), 32'd0);

    // 3: same sector with random valid gaps
    full_load("t3_gapped", 1'b1);

    // 4: abort after 100 data bytes, with a byte offered in the abort cycle
    wb = wa_q.size(); db = done_cnt;
    pulse_start();
    send(8'hA1, 1'b0);
    for (int i = 0; i < 100; i++) send(8'(i), 1'b0);
    in_data = 8'hEE; in_valid = 1'b1; abort = 1'b1;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("t4_done", 32'(done), 32'd1);
    check("t4_err_abort", 32'(err_code), 32'(ERR_ABORT));
    check("t4_no_write_on_abort", 32'(cache_wr_en), 32'd0);
    repeat (3) tick();
    check("t4_err_held", 32'(err_code), 32'(ERR_ABORT));
    check("t4_single_done", 32'(done_cnt - db), 32'd1);
    check_writes("t4_writes", wb, 100, 1'b0);

    // start and abort together in IDLE: abort wins, no load begins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_start_abort_busy", 32'(busy), 32'd0);
    check("idle_start_abort_err", 32'(err_code), 32'(ERR_ABORT));

`ifdef SECTOR_CRC16_EN
    // 5: CRC trailer, correct then corrupted
    c = 16'hFFFF;
    for (int i = 0; i < 512; i++) c = crc_step(c, 8'h00);
    for (int k = 0; k < 2; k++) begin
      wb = wa_q.size(); db = done_cnt;
      pulse_start();
      load(512, 1'b0, 1'b1);
      send(c[15:8], 1'b0);
      send(k == 0 ? c[7:0] : (c[7:0] ^ 8'h01), 1'b0);
      wait_done(db);
      check("t5_done", 32'(done_cnt - db), 32'd1);
      check("t5_err", 32'(done_err), k == 0 ? 32'(ERR_OK) : 32'(ERR_CRC));
      check_writes("t5_writes", wb, 512, 1'b1);
    end
`endif

    // 6: start during DATA is ignored, then reset mid-load
    wb = wa_q.size();
    pulse_start();
    send(8'hA1, 1'b0);
    for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
    pulse_start();
    check("t6_start_ignored_busy", 32'(busy), 32'd1);
    for (int i = 10; i < 20; i++) send(8'(i), 1'b0);
    tick();
    check_writes("t6_writes_continue", wb, 20, 1'b0);
    rst_n = 1'b0;
    #1;
    check("t6_reset_outputs", {11'd0, in_ready, busy, done, cache_wr_en, err_code, cache_addr, cache_din}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    full_load("t6_reload", 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
